mastermind_round_ctrl: RTL and testbench

MASTERMIND_ROUND_CTRL -- requirements
Module: mastermind_round_ctrl

---
 rtl/mastermind_pkg.sv | 31 +++
 rtl/mastermind_press_detect.sv | 24 ++
 rtl/mastermind_round_ctrl.sv | 145 ++++++++++++++
 tb/tb_mastermind_round_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared widths, the controller state enum and the score legality rule.
package mastermind_pkg;

    localparam int DIGIT_W = 3;
    localparam int SLOTS   = 4;
    localparam int CODE_W  = DIGIT_W * SLOTS;
    localparam int IDX_W   = 2;
    localparam int PHASE_W = 3;
    localparam int COUNT_W = 4;

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);

    typedef enum logic [PHASE_W-1:0] {
        LOAD_CODE  = 3'd0,
        LOAD_GUESS = 3'd1,
        SCORE_REQ  = 3'd2,
        SCORE_WAIT = 3'd3,
        WIN        = 3'd4,
        LOSE       = 3'd5
    } phase_t;

    // A score is only meaningful when red and red+white both fit in four pegs;
    // the sum is formed one bit wider so 7+7 cannot wrap into a legal value.
    function automatic logic result_legal(input logic [DIGIT_W-1:0] red,
                                          input logic [DIGIT_W-1:0] white);
        logic [DIGIT_W:0] sum;
        sum = {1'b0, red} + {1'b0, white};
        return (red <= 3'd4) && (sum <= 4'd4);
    endfunction

endpackage

// File: rtl/mastermind_press_detect.sv
// Turns the level-sensitive load key into a single-cycle press pulse.
module mastermind_press_detect
    import mastermind_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic press
);

    logic load_q;

    // Remember last cycle's key level so only the rising edge counts as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q <= 1'b0;
        end else begin
            load_q <= load;
        end
    end

    assign press = load & ~load_q;

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Mastermind round controller: collects code and guess digits, hands each
// complete guess to an external scorer, and tracks win/lose/error status.
module mastermind_round_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES   = 8,
    parameter int SCORE_TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIGIT_W-1:0]   data_in,
    output logic                 score_start,
    input  logic                 score_done,
    input  logic [DIGIT_W-1:0]   red_in,
    input  logic [DIGIT_W-1:0]   white_in,
    output logic [CODE_W-1:0]    code,
    output logic [CODE_W-1:0]    guess,
    output logic [DIGIT_W-1:0]   red_out,
    output logic [DIGIT_W-1:0]   white_out,
    output logic [COUNT_W-1:0]   guess_count,
    output logic [PHASE_W-1:0]   phase,
    output logic                 win,
    output logic                 lose,
    output logic                 score_err
);

    localparam int                 TMR_W    = $clog2(SCORE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(SCORE_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_GUESSES);

    phase_t               state;
    logic [IDX_W-1:0]     idx;
    logic [TMR_W-1:0]     timer;
    logic                 press;
    logic                 legal;
    logic [COUNT_W-1:0]   next_count;

    mastermind_press_detect u_press_detect (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .press (press)
    );

    assign legal      = result_legal(red_in, white_in);
    assign next_count = guess_count + COUNT_W'(1);
    assign phase      = state;

    // Round sequencing: digit entry, one scoring handshake per guess, and game end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD_CODE;
            idx         <= '0;
            timer       <= '0;
            code        <= '0;
            guess       <= '0;
            red_out     <= '0;
            white_out   <= '0;
            guess_count <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            score_err   <= 1'b0;
            score_start <= 1'b0;
        end else begin
            score_start <= 1'b0;
            case (state)
                LOAD_CODE: begin
                    if (press) begin
                        for (int k = 0; k < SLOTS; k++) begin
                            if (idx == IDX_W'(k)) begin
                                code[k*DIGIT_W +: DIGIT_W] <= data_in;
                            end
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_SLOT) begin
                            state <= LOAD_GUESS;
                        end
                    end
                end
                LOAD_GUESS: begin
                    if (press) begin
                        for (int k = 0; k < SLOTS; k++) begin
                            if (idx == IDX_W'(k)) begin
                                guess[k*DIGIT_W +: DIGIT_W] <= data_in;
                            end
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx == LAST_SLOT) begin
                            state       <= SCORE_REQ;
                            score_start <= 1'b1;
                        end
                    end
                end
                SCORE_REQ: begin
                    timer <= '0;
                    state <= SCORE_WAIT;
                end
                SCORE_WAIT: begin
                    if (score_done && legal) begin
                        red_out     <= red_in;
                        white_out   <= white_in;
                        guess_count <= next_count;
                        score_err   <= 1'b0;
                        if (red_in == 3'd4) begin
                            state <= WIN;
                            win   <= 1'b1;
                        end else if (next_count == MAX_CNT) begin
                            state <= LOSE;
                            lose  <= 1'b1;
                        end else begin
                            state <= LOAD_GUESS;
                            idx   <= '0;
                        end
                    end else if (score_done || (timer == TMR_LAST)) begin
                        score_err <= 1'b1;
                        state     <= LOAD_GUESS;
                        idx       <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WIN, LOSE: begin
                    if (press) begin
                        state       <= LOAD_CODE;
                        idx         <= '0;
                        code        <= '0;
                        guess       <= '0;
                        red_out     <= '0;
                        white_out   <= '0;
                        guess_count <= '0;
                        win         <= 1'b0;
                        lose        <= 1'b0;
                        score_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD_CODE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Scoreboard bench for mastermind_round_ctrl: a game-level model predicts each
// scoring request and each scoring outcome, and a monitor checks them as they appear.
`timescale 1ns/1ps
module tb_mastermind_round_ctrl;
    import mastermind_pkg::*;

    localparam int MAX_G = 2;
    localparam int TMO   = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [2:0]  data_in;
    logic        score_start;
    logic        score_done;
    logic [2:0]  red_in;
    logic [2:0]  white_in;
    logic [11:0] code;
    logic [11:0] guess;
    logic [2:0]  red_out;
    logic [2:0]  white_out;
    logic [3:0]  guess_count;
    logic [2:0]  phase;
    logic        win;
    logic        lose;
    logic        score_err;

    always #5 clk = ~clk;

    mastermind_round_ctrl #(
        .MAX_GUESSES   (MAX_G),
        .SCORE_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .score_start (score_start),
        .score_done  (score_done),
        .red_in      (red_in),
        .white_in    (white_in),
        .code        (code),
        .guess       (guess),
        .red_out     (red_out),
        .white_out   (white_out),
        .guess_count (guess_count),
        .phase       (phase),
        .win         (win),
        .lose        (lose),
        .score_err   (score_err)
    );

    typedef struct packed {
        logic [11:0] code;
        logic [11:0] guess;
        logic [3:0]  cnt;
    } start_exp_t;

    typedef struct packed {
        logic [2:0] phase;
        logic [2:0] red;
        logic [2:0] white;
        logic [3:0] cnt;
        logic       win;
        logic       lose;
        logic       err;
    } res_exp_t;

    start_exp_t start_q[$];
    res_exp_t   res_q[$];
    int checks = 0;
    int errors = 0;

    // Game-level model: digits as plain integers, status as the rules describe it.
    int     m_code[4];
    int     m_guess[4];
    int     m_idx;
    int     m_count;
    int     m_red;
    int     m_white;
    bit     m_win;
    bit     m_lose;
    bit     m_err;
    phase_t m_phase;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] pack_digits(input int d0, input int d1, input int d2, input int d3);
        int v;
        v = d0 + (d1 * 8) + (d2 * 64) + (d3 * 512);
        return 12'(v);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_code[k]  = 0;
            m_guess[k] = 0;
        end
        m_idx = 0; m_count = 0; m_red = 0; m_white = 0;
        m_win = 0; m_lose = 0; m_err = 0;
        m_phase = LOAD_CODE;
    endtask

    task automatic model_press(input int d);
        start_exp_t e;
        case (m_phase)
            LOAD_CODE: begin
                m_code[m_idx] = d;
                m_idx++;
                if (m_idx == 4) begin
                    m_idx = 0;
                    m_phase = LOAD_GUESS;
                end
            end
            LOAD_GUESS: begin
                m_guess[m_idx] = d;
                m_idx++;
                if (m_idx == 4) begin
                    m_idx = 0;
                    m_phase = SCORE_REQ;
                    e.code  = pack_digits(m_code[0], m_code[1], m_code[2], m_code[3]);
                    e.guess = pack_digits(m_guess[0], m_guess[1], m_guess[2], m_guess[3]);
                    e.cnt   = 4'(m_count);
                    start_q.push_back(e);
                end
            end
            WIN, LOSE: model_clear();
            default: ;
        endcase
    endtask

    task automatic check_output(input string tag);
        compare({tag, ".phase"},       32'(phase),       32'(m_phase));
        compare({tag, ".code"},        32'(code),        32'(pack_digits(m_code[0], m_code[1], m_code[2], m_code[3])));
        compare({tag, ".guess"},       32'(guess),       32'(pack_digits(m_guess[0], m_guess[1], m_guess[2], m_guess[3])));
        compare({tag, ".red_out"},     32'(red_out),     32'(m_red));
        compare({tag, ".white_out"},   32'(white_out),   32'(m_white));
        compare({tag, ".guess_count"}, 32'(guess_count), 32'(m_count));
        compare({tag, ".win"},         32'(win),         32'(m_win));
        compare({tag, ".lose"},        32'(lose),        32'(m_lose));
        compare({tag, ".score_err"},   32'(score_err),   32'(m_err));
        compare({tag, ".score_start"}, 32'(score_start), 32'(0));
    endtask

    // One key press: load high for a single cycle, then low for a cycle.
    task automatic apply_stimulus(input int d);
        @(posedge clk); #1;
        data_in = 3'(d);
        load    = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
        model_press(d);
    endtask

    task automatic enter_four(input int d0, input int d1, input int d2, input int d3);
        apply_stimulus(d0);
        apply_stimulus(d1);
        apply_stimulus(d2);
        apply_stimulus(d3);
    endtask

    // The scoring request must show up in the cycle right after the last guess digit.
    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (score_start !== 1'b1 && n < 8);
        compare("start_latency", 32'(n), 32'(1));
    endtask

    // Play the scorer for one pass; returns at a negedge with the outcome visible.
    task automatic score_round(input bit give_done, input int delay, input int red,
                               input int white, input bit press_in_wait);
        res_exp_t e;
        bit       legal;
        int       n;
        legal = give_done && (red <= 4) && (red + white <= 4);
        if (legal) begin
            m_red = red; m_white = white; m_count++; m_err = 0;
            if (red == 4) begin
                m_phase = WIN; m_win = 1;
            end else if (m_count == MAX_G) begin
                m_phase = LOSE; m_lose = 1;
            end else begin
                m_phase = LOAD_GUESS; m_idx = 0;
            end
        end else begin
            m_err = 1; m_phase = LOAD_GUESS; m_idx = 0;
        end
        e.phase = 3'(m_phase); e.red = 3'(m_red); e.white = 3'(m_white);
        e.cnt = 4'(m_count); e.win = m_win; e.lose = m_lose; e.err = m_err;
        res_q.push_back(e);
        if (give_done) begin
            for (int i = 1; i <= delay; i++) begin
                @(posedge clk); #1;
                load    = press_in_wait && (i == 1);
                data_in = 3'($urandom_range(0, 7));
                if (i == delay) begin
                    score_done = 1'b1;
                    red_in     = 3'(red);
                    white_in   = 3'(white);
                end
            end
            @(posedge clk); #1;
            score_done = 1'b0;
            load       = 1'b0;
            @(negedge clk);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (phase != 3'(LOAD_GUESS) && n < 60);
            compare("timeout_latency", 32'(n), 32'(TMO + 1));
        end
        check_output("after_score");
    endtask

    task automatic random_round();
        int kind, r, w, common, cc, cg;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            score_round(1'b0, 0, 0, 0, 1'b0);
        end else begin
            if (kind <= 2) begin
                r = $urandom_range(0, 7);
                w = $urandom_range(0, 7);
            end else if (kind == 3) begin
                r = 4; w = 0;
            end else begin
                r = 0; common = 0;
                for (int k = 0; k < 4; k++) if (m_code[k] == m_guess[k]) r++;
                for (int c = 0; c < 8; c++) begin
                    cc = 0; cg = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (m_code[k] == c)  cc++;
                        if (m_guess[k] == c) cg++;
                    end
                    common += (cc < cg) ? cc : cg;
                end
                w = common - r;
            end
            score_round(1'b1, $urandom_range(1, 3), r, w, 1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: checks every scoring request and every exit from the scoring wait.
    logic [2:0] prev_phase = 3'(LOAD_CODE);
    always @(negedge clk) begin
        start_exp_t se;
        res_exp_t   re;
        if (reset) begin
            prev_phase = 3'(LOAD_CODE);
        end else begin
            if (score_start) begin
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_start actual=1 required=0");
                end else begin
                    se = start_q.pop_front();
                    compare("start.code",  32'(code),        32'(se.code));
                    compare("start.guess", 32'(guess),       32'(se.guess));
                    compare("start.count", 32'(guess_count), 32'(se.cnt));
                end
            end
            if (prev_phase == 3'(SCORE_WAIT) && phase != 3'(SCORE_WAIT)) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_result actual=%0h required=none", phase);
                end else begin
                    re = res_q.pop_front();
                    compare("result", 32'({phase, red_out, white_out, guess_count, win, lose, score_err}), 32'(re));
                end
            end
            prev_phase = phase;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; load = 1'b0; data_in = '0;
        score_done = 1'b0; red_in = '0; white_in = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("reset");

        // Code entry, then a held key that must only commit one digit.
        enter_four(1, 2, 3, 4);
        @(negedge clk);
        compare("code_4321", 32'(code), 32'(12'o4321));
        check_output("code_loaded");
        @(posedge clk); #1;
        data_in = 3'd1; load = 1'b1;
        repeat (10) @(posedge clk);
        #1 load = 1'b0;
        model_press(1);
        @(negedge clk);
        check_output("held_load");

        // Winning guess scored two cycles after the request.
        apply_stimulus(2); apply_stimulus(3); apply_stimulus(4);
        wait_start();
        score_round(1'b1, 2, 4, 0, 1'b0);
        compare("win_flag", 32'(win), 32'(1));
        apply_stimulus(5);
        @(negedge clk);
        check_output("new_game_after_win");

        // Scorer never answers, then answers with an impossible result.
        enter_four(7, 6, 5, 4);
        enter_four(0, 1, 2, 3);
        wait_start();
        score_round(1'b0, 0, 0, 0, 1'b0);
        compare("timeout_err", 32'(score_err), 32'(1));
        enter_four(3, 3, 1, 1);
        wait_start();
        score_round(1'b1, 2, 3, 2, 1'b1);
        compare("illegal_err", 32'(score_err), 32'(1));

        // Two accepted non-winning guesses exhaust the game.
        enter_four(2, 2, 2, 2);
        wait_start();
        score_round(1'b1, 1, 1, 2, 1'b0);
        enter_four(4, 4, 4, 4);
        wait_start();
        score_round(1'b1, 3, 1, 2, 1'b0);
        compare("lose_flag", 32'(lose), 32'(1));
        apply_stimulus(0);
        @(negedge clk);
        check_output("new_game_after_lose");

        // Reset collides with a score_done strobe.
        enter_four(1, 1, 1, 1);
        enter_four(1, 1, 1, 1);
        wait_start();
        @(posedge clk); #1;
        reset = 1'b1; score_done = 1'b1; red_in = 3'd4; white_in = 3'd0;
        @(posedge clk); #1;
        reset = 1'b0; score_done = 1'b0;
        model_clear();
        @(negedge clk);
        check_output("reset_mid_score");

        // A key held through reset release commits exactly one digit.
        @(posedge clk); #1;
        reset = 1'b1; load = 1'b1; data_in = 3'd6;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 load = 1'b0;
        model_clear();
        model_press(6);
        @(negedge clk);
        compare("press_through_reset", 32'(code), 32'(12'o0006));
        check_output("press_through_reset");

        // Randomised play driven by the model's view of the game.
        for (int it = 0; it < 200; it++) begin
            case (m_phase)
                LOAD_GUESS: begin
                    apply_stimulus($urandom_range(0, 7));
                    if (m_phase == SCORE_REQ) begin
                        wait_start();
                        random_round();
                    end
                end
                WIN, LOSE: begin
                    apply_stimulus($urandom_range(0, 7));
                    @(negedge clk);
                    check_output("random_new_game");
                end
                default: begin
                    apply_stimulus($urandom_range(0, 7));
                    @(negedge clk);
                    check_output("random_code");
                end
            endcase
        end

        repeat (3) @(negedge clk);
        compare("start_queue_empty",  32'(start_q.size()), 32'(0));
        compare("result_queue_empty", 32'(res_q.size()),   32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
